// File: rtl/me_result_sink_if.sv
// Result-side bundle of the motion-estimation core: the incoming result strobe
// and the ready/valid stream that carries buffered, vector-converted results out.
interface me_result_sink_if #(
  parameter int SAD_W   = 14,
  parameter int COORD_W = 5,
  parameter int OUT_W   = 30
);
  logic               data_valid;
  logic [SAD_W-1:0]   MSAD;
  logic [COORD_W-1:0] MSAD_row;
  logic [COORD_W-1:0] MSAD_column;
  logic               out_ready;
  logic               out_valid;
  logic [OUT_W-1:0]   out_data;

  // master: the environment (ME core plus downstream consumer)
  modport master (
    output data_valid, MSAD, MSAD_row, MSAD_column, out_ready,
    input  out_valid, out_data
  );

  // slave: the result sink itself
  modport slave (
    input  data_valid, MSAD, MSAD_row, MSAD_column, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/me_result_sink.sv
// Buffers per-macroblock ME results as {idx, mv_y, mv_x, sad} in a small FWFT FIFO,
// tracks the frame-minimum SAD and raises finish_flag once the frame is collected and drained.
module me_result_sink #(
  parameter int  NUM_BLOCKS    = 16,
  parameter int  FIFO_DEPTH    = 4,
  parameter int  SAD_W         = 14,
  parameter int  COORD_W       = 5,
  parameter int  SEARCH_OFFSET = 16,
  localparam int IDX_W         = $clog2(NUM_BLOCKS),
  localparam int MV_W          = COORD_W + 1,
  localparam int OUT_W         = IDX_W + 2 * MV_W + SAD_W
) (
  input  logic                clk,
  input  logic                rst,
  me_result_sink_if.slave     bus,
  output logic [SAD_W-1:0]    best_sad,
  output logic [IDX_W-1:0]    best_idx,
  output logic                overflow,
  output logic                extra,
  output logic                finish_flag
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    COLLECT,
    DRAIN,
    DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   blk_cnt;
  logic [OUT_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               take;
  logic               full;
  logic               push;
  logic               pop;
  logic [MV_W-1:0]    mv_y;
  logic [MV_W-1:0]    mv_x;
  logic [OUT_W-1:0]   entry;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mv_y       = {1'b0, bus.MSAD_row}    - MV_W'(SEARCH_OFFSET);
    mv_x       = {1'b0, bus.MSAD_column} - MV_W'(SEARCH_OFFSET);
    entry      = {blk_cnt, mv_y, mv_x, bus.MSAD};
    take       = (state == COLLECT) && bus.data_valid;
    full       = (count == CNT_W'(FIFO_DEPTH));
    pop        = (count != '0) && bus.out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push       = take && (!full || pop);
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: storage is left unreset; out_data is masked to zero while empty so stale words never show.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      blk_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      bus.out_valid <= 1'b0;
      best_sad  <= '1;
      best_idx  <= '0;
      overflow  <= 1'b0;
      extra     <= 1'b0;
    end else begin
      count         <= count_next;
      bus.out_valid <= (count_next != '0);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case (state)
        COLLECT: begin
          if (bus.data_valid) begin
            blk_cnt <= blk_cnt + 1'b1;
            if (!push) overflow <= 1'b1;
            // Strict compare: on a tie the earlier block keeps the title.
            if (bus.MSAD < best_sad) begin
              best_sad <= bus.MSAD;
              best_idx <= blk_cnt;
            end
            if (blk_cnt == IDX_W'(NUM_BLOCKS - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.data_valid) extra <= 1'b1;
          if (count_next == '0) state <= DONE;
        end
        default: begin
          if (bus.data_valid) extra <= 1'b1;
        end
      endcase
    end
  end

  assign bus.out_data = bus.out_valid ? mem[rd_ptr] : '0;
  assign finish_flag  = (state == DONE);

endmodule

// File: tb/tb_me_result_sink.sv
// Self-checking bench for me_result_sink: a queue scoreboard fed at stimulus time,
// a per-cycle reference of the flags, and directed checks for the key scenarios.
module tb_me_result_sink;

  localparam int NB    = 16;
  localparam int DEPTH = 4;
  localparam int OUT_W = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] best_sad;
  logic [3:0]  best_idx;
  logic        overflow;
  logic        extra;
  logic        finish_flag;

  int total = 0;
  int bad   = 0;

  me_result_sink_if #(.SAD_W(14), .COORD_W(5), .OUT_W(OUT_W)) bus ();

  me_result_sink dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .best_sad    (best_sad),
    .best_idx    (best_idx),
    .overflow    (overflow),
    .extra       (extra),
    .finish_flag (finish_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state, advanced at each falling edge for the rising edge that follows.
  logic [OUT_W-1:0] q[$];
  int          m_state;   // 0 collect, 1 drain, 2 done
  int          m_blk;
  logic [13:0] m_best;
  logic [3:0]  m_bidx;
  logic        m_ovf;
  logic        m_extra;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_state = 0;
      m_blk   = 0;
      m_best  = '1;
      m_bidx  = '0;
      m_ovf   = 1'b0;
      m_extra = 1'b0;
    end else begin
      int          cur;
      bit          was_full;
      bit          pop;
      logic [5:0]  mvy;
      logic [5:0]  mvx;
      check("out_valid", bus.out_valid, q.size() != 0);
      check("best_sad",  best_sad, m_best);
      check("best_idx",  best_idx, m_bidx);
      check("overflow",  overflow, m_ovf);
      check("extra",     extra, m_extra);
      check("finish",    finish_flag, m_state == 2);
      cur      = m_state;
      was_full = (q.size() == DEPTH);
      pop      = (q.size() != 0) && bus.out_ready;
      if (pop) begin
        check("out_data", bus.out_data, q[0]);
        void'(q.pop_front());
      end
      if (bus.data_valid) begin
        if (cur == 0) begin
          mvy = 6'(int'(bus.MSAD_row) - 16);
          mvx = 6'(int'(bus.MSAD_column) - 16);
          if (!was_full || pop) q.push_back({4'(m_blk), mvy, mvx, bus.MSAD});
          else m_ovf = 1'b1;
          if (bus.MSAD < m_best) begin
            m_best = bus.MSAD;
            m_bidx = 4'(m_blk);
          end
          if (m_blk == NB - 1) m_state = 1;
          m_blk++;
        end else begin
          m_extra = 1'b1;
        end
      end
      if (cur == 1 && q.size() == 0) m_state = 2;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sad, input int row, input int col);
    bus.data_valid  = 1'b1;
    bus.MSAD        = 14'(sad);
    bus.MSAD_row    = 5'(row);
    bus.MSAD_column = 5'(col);
    cyc();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    bus.data_valid = 1'b0;
    bus.out_ready  = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data",  bus.out_data, '0);
    check("rst_best_sad",  best_sad, 14'h3fff);
    check("rst_best_idx",  best_idx, 4'd0);
    check("rst_overflow",  overflow, 1'b0);
    check("rst_extra",     extra, 1'b0);
    check("rst_finish",    finish_flag, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_finish();
    for (int i = 0; i < 50 && !finish_flag; i++) cyc();
    check("finish_wait", finish_flag, 1'b1);
  endtask

  initial begin
    bus.data_valid  = 1'b0;
    bus.MSAD        = '0;
    bus.MSAD_row    = '0;
    bus.MSAD_column = '0;
    bus.out_ready   = 1'b0;
    repeat (2) @(posedge clk);

    // Vector conversion on a single result.
    do_reset();
    bus.out_ready = 1'b1;
    drive(100, 0, 31);
    bus.data_valid = 1'b0;
    check("vec_valid", bus.out_valid, 1'b1);
    check("vec_data",  bus.out_data, {4'd0, 6'h30, 6'h0f, 14'd100});
    check("vec_best",  best_sad, 14'd100);
    cyc();

    // Full frame, back-to-back, descending SADs.
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < NB; i++) drive(500 - i, $urandom_range(0, 31), $urandom_range(0, 31));
    bus.data_valid = 1'b0;
    check("frame_best_sad", best_sad, 14'd485);
    check("frame_best_idx", best_idx, 4'd15);
    check("frame_fin_early", finish_flag, 1'b0);
    cyc();
    check("frame_fin", finish_flag, 1'b1);
    check("frame_ovf", overflow, 1'b0);
    cyc();

    // Overflow: five results into a stalled four-entry FIFO.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1000 + i, i, 31 - i);
    bus.data_valid = 1'b0;
    check("ovf_set", overflow, 1'b1);
    check("ovf_valid", bus.out_valid, 1'b1);
    check("ovf_hold", bus.out_data[OUT_W-1 -: 4], 4'd0);
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    check("ovf_drained", bus.out_valid, 1'b0);
    drive(50, 16, 16);
    bus.data_valid = 1'b0;
    check("ovf_next_idx", bus.out_data[OUT_W-1 -: 4], 4'd5);
    cyc();

    // Full FIFO with simultaneous push and pop; mid-frame reset follows with data inside.
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(700 + i, 10, 20);
    bus.out_ready = 1'b1;
    drive(600, 3, 4);
    bus.data_valid = 1'b0;
    bus.out_ready  = 1'b0;
    check("sim_ovf", overflow, 1'b0);
    drive(650, 5, 5);
    bus.data_valid = 1'b0;
    check("sim_still_full", overflow, 1'b1);
    cyc();

    // Ties keep the earlier block; post-frame results only raise extra.
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < NB; i++)
      drive((i == 2 || i == 7) ? 200 : 300 + i, $urandom_range(0, 31), $urandom_range(0, 31));
    bus.data_valid = 1'b0;
    wait_finish();
    check("tie_idx", best_idx, 4'd2);
    check("tie_sad", best_sad, 14'd200);
    drive(1, 0, 0);
    bus.data_valid = 1'b0;
    check("extra_set", extra, 1'b1);
    check("extra_best", best_sad, 14'd200);
    check("extra_fin", finish_flag, 1'b1);
    check("extra_fifo", bus.out_valid, 1'b0);
    cyc();
    check("sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
